// File: rtl/adc_dual_reader.sv
// adc_dual_reader
// Controller for a simultaneous-sampling serial ADC: CNVST pulse, BUSY handshake,
// then NUM_CH DOUT lines shifted in MSB first under one shared CS/SCLK, with
// optional 2^AVG_LOG2-sample averaging.
// Optional BUSY watchdog: define ADC_BUSY_TIMEOUT_EN to abort stuck conversions
// with a one-cycle ERR pulse; otherwise ERR is constant 0.

module adc_dual_reader #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned DATA_BITS      = 14,
    parameter int unsigned SCLK_DIV       = 2,
    parameter int unsigned CNV_LOW        = 4,
    parameter int unsigned AVG_LOG2       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        START,
    output logic                        READY,
    output logic                        CNVST_ADC,
    input  logic                        BUSY_ADC,
    output logic                        CS_ADC,
    output logic                        SCLK_ADC,
    input  logic [NUM_CH-1:0]           DOUT_ADC,
    output logic [NUM_CH*DATA_BITS-1:0] DATA,
    output logic                        VALID,
    output logic                        ERR
);

    localparam int unsigned AccW   = DATA_BITS + AVG_LOG2;
    localparam int unsigned NumAvg = 1 << AVG_LOG2;
    localparam int unsigned CntW   = AVG_LOG2 + 1;
    localparam int unsigned MaxA   = (CNV_LOW > SCLK_DIV) ? CNV_LOW : SCLK_DIV;
    localparam int unsigned MaxCyc = (MaxA > TIMEOUT_CYCLES) ? MaxA : TIMEOUT_CYCLES;
    localparam int unsigned CycW   = $clog2(MaxCyc + 1);
    localparam int unsigned BitW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitHi,
        StWaitLo,
        StShift,
        StAcc
    } state_e;

    state_e                               state_q, state_d;
    logic [CycW-1:0]                      cyc_q, cyc_d;    // CONV/SHIFT phase timer, watchdog
    logic [BitW-1:0]                      bit_q, bit_d;
    logic                                 ph_q, ph_d;      // 0: SCLK high phase, 1: low phase
    logic [CntW-1:0]                      cnt_q, cnt_d;    // conversions done in this run
    logic [NUM_CH-1:0][DATA_BITS-1:0]     sh_q, sh_d;
    logic [NUM_CH-1:0][AccW-1:0]          acc_q, acc_d;
    logic [NUM_CH*DATA_BITS-1:0]          data_q, data_d;
    logic                                 valid_q, valid_d;
    logic                                 err_q, err_d;
    logic                                 cnvst_q, cnvst_d;
    logic                                 cs_q, cs_d;
    logic                                 sclk_q, sclk_d;
    logic                                 busy_meta_q, busy_meta_d;
    logic                                 busy_sync_q, busy_sync_d;

    logic [NUM_CH-1:0][AccW-1:0]          acc_sum;
    logic [NUM_CH*DATA_BITS-1:0]          data_avg;

    // Next-state and output logic for the conversion sequencer.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        ph_d        = ph_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        acc_d       = acc_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        cnvst_d     = cnvst_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        busy_meta_d = BUSY_ADC;
        busy_sync_d = busy_meta_q;
        acc_sum     = '0;
        data_avg    = '0;

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            acc_sum[c] = acc_q[c] + AccW'(sh_q[c]);
            data_avg[c*DATA_BITS +: DATA_BITS] = DATA_BITS'(acc_sum[c] >> AVG_LOG2);
        end

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    cyc_d   = '0;
                    cnvst_d = 1'b0;
                    state_d = StConv;
                end
            end
            StConv: begin
                if (cyc_q == CycW'(CNV_LOW - 1)) begin
                    cnvst_d = 1'b1;
                    cyc_d   = '0;
                    state_d = StWaitHi;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StWaitHi: begin
                if (busy_sync_q) begin
                    cyc_d   = '0;
                    state_d = StWaitLo;
                end
`ifdef ADC_BUSY_TIMEOUT_EN
                else if (cyc_q == CycW'(TIMEOUT_CYCLES - 1)) begin
                    cnvst_d = 1'b1;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b1;
                    err_d   = 1'b1;
                    cyc_d   = '0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
`endif
            end
            StWaitLo: begin
                if (!busy_sync_q) begin
                    cs_d    = 1'b0;
                    cyc_d   = '0;
                    bit_d   = '0;
                    ph_d    = 1'b0;
                    state_d = StShift;
                end
`ifdef ADC_BUSY_TIMEOUT_EN
                else if (cyc_q == CycW'(TIMEOUT_CYCLES - 1)) begin
                    cnvst_d = 1'b1;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b1;
                    err_d   = 1'b1;
                    cyc_d   = '0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
`endif
            end
            StShift: begin
                if (cyc_q == CycW'(SCLK_DIV - 1)) begin
                    cyc_d = '0;
                    if (!ph_q) begin
                        // Last cycle of the high phase: capture every DOUT line.
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            sh_d[c] = {sh_q[c][DATA_BITS-2:0], DOUT_ADC[c]};
                        end
                        sclk_d = 1'b0;
                        ph_d   = 1'b1;
                    end else if (bit_q == BitW'(DATA_BITS - 1)) begin
                        sclk_d  = 1'b1;
                        cs_d    = 1'b1;
                        ph_d    = 1'b0;
                        state_d = StAcc;
                    end else begin
                        sclk_d = 1'b1;
                        ph_d   = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StAcc: begin
                acc_d = acc_sum;
                if (cnt_q != CntW'(NumAvg - 1)) begin
                    cnt_d   = cnt_q + 1'b1;
                    cyc_d   = '0;
                    cnvst_d = 1'b0;
                    state_d = StConv;
                end else begin
                    data_d  = data_avg;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            cyc_q       <= '0;
            bit_q       <= '0;
            ph_q        <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            cnvst_q     <= 1'b1;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            ph_q        <= ph_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            cnvst_q     <= cnvst_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            busy_meta_q <= busy_meta_d;
            busy_sync_q <= busy_sync_d;
        end
    end

    assign READY     = (state_q == StIdle);
    assign CNVST_ADC = cnvst_q;
    assign CS_ADC    = cs_q;
    assign SCLK_ADC  = sclk_q;
    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_adc_dual_reader.sv
// tb_adc_dual_reader
// Four instances: A defaults, B with 4-sample averaging, C 4x16-bit at SCLK_DIV=1,
// D with BUSY tied low for the watchdog (ADC_BUSY_TIMEOUT_EN selects expectations).

module tb_adc_dual_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [63:0] exp;
    } vec_t;

    vec_t a_vec [4];
    vec_t c_vec [4];

    // ---------------- instance A: defaults ----------------
    logic        a_start = 1'b0, a_busy = 1'b0;
    logic        a_ready, a_cnv, a_cs, a_sclk, a_valid, a_err;
    logic [1:0]  a_dout = '0;
    logic [27:0] a_data;
    logic [27:0] a_word = '0, a_sh = '0;
    int          a_ncnv = 0, a_nf = 0, a_nvalid = 0;
    time         a_cnv_t = 0, a_cnv_w = 0;

    adc_dual_reader u_dut_a (
        .CLK(clk), .RST_N(rst_n), .START(a_start), .READY(a_ready), .CNVST_ADC(a_cnv),
        .BUSY_ADC(a_busy), .CS_ADC(a_cs), .SCLK_ADC(a_sclk), .DOUT_ADC(a_dout),
        .DATA(a_data), .VALID(a_valid), .ERR(a_err)
    );

    always @(negedge a_cnv) begin
        a_ncnv++;
        a_cnv_t = $time;
        #40;
        a_busy = 1'b1;
        #720;
        a_busy = 1'b0;
    end
    always @(posedge a_cnv) a_cnv_w = $time - a_cnv_t;
    always @(negedge a_cs or negedge a_sclk) begin
        if (a_sclk) begin
            a_sh = a_word;
            a_nf = 0;
        end else begin
            a_nf++;
            for (int k = 0; k < 2; k++) a_sh[k*14 +: 14] = {a_sh[k*14 +: 13], 1'b0};
        end
        for (int k = 0; k < 2; k++) a_dout[k] = a_sh[k*14 + 13];
    end
    always @(posedge clk) if (a_valid === 1'b1) a_nvalid++;

    // ---------------- instance B: AVG_LOG2 = 2 ----------------
    logic        b_start = 1'b0, b_busy = 1'b0;
    logic        b_ready, b_cnv, b_cs, b_sclk, b_valid, b_err;
    logic [1:0]  b_dout = '0;
    logic [27:0] b_data;
    logic [27:0] b_sh = '0;
    logic [13:0] b_seq [4] = '{14'd100, 14'd101, 14'd102, 14'd104};
    int          b_idx = 0, b_ncnv = 0, b_nvalid = 0;

    adc_dual_reader #(.AVG_LOG2(2)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .START(b_start), .READY(b_ready), .CNVST_ADC(b_cnv),
        .BUSY_ADC(b_busy), .CS_ADC(b_cs), .SCLK_ADC(b_sclk), .DOUT_ADC(b_dout),
        .DATA(b_data), .VALID(b_valid), .ERR(b_err)
    );

    always @(negedge b_cnv) begin
        b_ncnv++;
        #40;
        b_busy = 1'b1;
        #720;
        b_busy = 1'b0;
    end
    always @(negedge b_cs or negedge b_sclk) begin
        if (b_sclk) begin
            b_sh = {14'd7, b_seq[b_idx % 4]};
            b_idx++;
        end else begin
            for (int k = 0; k < 2; k++) b_sh[k*14 +: 14] = {b_sh[k*14 +: 13], 1'b0};
        end
        for (int k = 0; k < 2; k++) b_dout[k] = b_sh[k*14 + 13];
    end
    always @(posedge clk) if (b_valid === 1'b1) b_nvalid++;

    // ---------------- instance C: 4 x 16 bits, SCLK_DIV = 1 ----------------
    logic        c_start = 1'b0, c_busy = 1'b0;
    logic        c_ready, c_cnv, c_cs, c_sclk, c_valid, c_err;
    logic [3:0]  c_dout = '0;
    logic [63:0] c_data;
    logic [63:0] c_word = '0, c_sh = '0;
    int          c_nf = 0;
    time         c_first_t = 0, c_last_t = 0;

    adc_dual_reader #(.NUM_CH(4), .DATA_BITS(16), .SCLK_DIV(1)) u_dut_c (
        .CLK(clk), .RST_N(rst_n), .START(c_start), .READY(c_ready), .CNVST_ADC(c_cnv),
        .BUSY_ADC(c_busy), .CS_ADC(c_cs), .SCLK_ADC(c_sclk), .DOUT_ADC(c_dout),
        .DATA(c_data), .VALID(c_valid), .ERR(c_err)
    );

    always @(negedge c_cnv) begin
        #40;
        c_busy = 1'b1;
        #720;
        c_busy = 1'b0;
    end
    always @(negedge c_cs or negedge c_sclk) begin
        if (c_sclk) begin
            c_sh = c_word;
            c_nf = 0;
        end else begin
            c_nf++;
            if (c_nf == 1) c_first_t = $time;
            c_last_t = $time;
            for (int k = 0; k < 4; k++) c_sh[k*16 +: 16] = {c_sh[k*16 +: 15], 1'b0};
        end
        for (int k = 0; k < 4; k++) c_dout[k] = c_sh[k*16 + 15];
    end

    // ---------------- instance D: BUSY stuck low, watchdog ----------------
    logic        d_start = 1'b0;
    logic        d_ready, d_cnv, d_cs, d_sclk, d_valid, d_err;
    logic [27:0] d_data;

    adc_dual_reader #(.TIMEOUT_CYCLES(64)) u_dut_d (
        .CLK(clk), .RST_N(rst_n), .START(d_start), .READY(d_ready), .CNVST_ADC(d_cnv),
        .BUSY_ADC(1'b0), .CS_ADC(d_cs), .SCLK_ADC(d_sclk), .DOUT_ADC(2'b00),
        .DATA(d_data), .VALID(d_valid), .ERR(d_err)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the edge where VALID rose (VALID still high).
    task automatic wait_valid(input int which, input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            seen = (which == 0) ? a_valid : (which == 1) ? b_valid : c_valid;
        end
        chk({name, "_valid_seen"}, 64'(seen), 1);
    endtask

    task automatic a_go(input logic [27:0] word);
        a_word = word;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_wait_cs_low();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = !a_cs;
        end
        chk("a_cs_low_seen", 64'(seen), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  n0, v0, n;
        bit  seen;

        a_vec[0] = '{word: {36'd0, 14'h1234, 14'h2A5B}, exp: 64'h48D2A5B};
        a_vec[1] = '{word: {36'd0, 14'h0000, 14'h3FFF}, exp: 64'h0003FFF};
        a_vec[2] = '{word: {36'd0, 14'h3FFF, 14'h0000}, exp: 64'hFFFC000};
        a_vec[3] = '{word: {36'd0, 14'h2AAA, 14'h1555}, exp: 64'hAAA9555};
        c_vec[0] = '{word: {16'h1000, 16'h0100, 16'h0010, 16'h0001},
                     exp: 64'h1000_0100_0010_0001};
        c_vec[1] = '{word: {16'h2000, 16'h0200, 16'h0020, 16'h0002},
                     exp: 64'h2000_0200_0020_0002};
        c_vec[2] = '{word: {16'h4000, 16'h0400, 16'h0040, 16'h0004},
                     exp: 64'h4000_0400_0040_0004};
        c_vec[3] = '{word: {16'h8000, 16'h0800, 16'h0080, 16'h0008},
                     exp: 64'h8000_0800_0080_0008};

        // Reset state.
        repeat (3) tick();
        chk("rst_cnvst", a_cnv, 1);
        chk("rst_cs", a_cs, 1);
        chk("rst_sclk", a_sclk, 1);
        chk("rst_data", a_data, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_err", a_err, 0);
        chk("rst_ready", {a_ready, b_ready, c_ready, d_ready}, 4'hF);
        chk("rst_err_bcd", {b_err, c_err, d_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single-shot conversions on the default instance.
        for (int v = 0; v < 4; v++) begin
            n0 = a_ncnv;
            v0 = a_nvalid;
            a_go(a_vec[v].word[27:0]);
            wait_valid(0, 1000, $sformatf("a_vec%0d", v));
            chk($sformatf("a_data[%0d]", v), a_data, a_vec[v].exp);
            chk($sformatf("a_ready_at_valid[%0d]", v), a_ready, 1);
            chk($sformatf("a_sclk_falls[%0d]", v), a_nf, 14);
            chk($sformatf("a_cnvst_low_time[%0d]", v), a_cnv_w, 40);
            repeat (3) tick();
            chk($sformatf("a_valid_pulses[%0d]", v), a_nvalid - v0, 1);
            chk($sformatf("a_cnvst_pulses[%0d]", v), a_ncnv - n0, 1);
            chk($sformatf("a_data_hold[%0d]", v), a_data, a_vec[v].exp);
        end

        // Averaging: 100, 101, 102, 104 on ch0 and 7 on ch1.
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_valid(1, 2000, "b_avg");
        chk("b_avg_ch0", b_data[13:0], 101);
        chk("b_avg_ch1", b_data[27:14], 7);
        repeat (3) tick();
        chk("b_cnvst_pulses", b_ncnv, 4);
        chk("b_valid_pulses", b_nvalid, 1);

        // Four channels, walking ones, 2-cycle SCLK period.
        for (int v = 0; v < 4; v++) begin
            c_word = c_vec[v].word;
            @(negedge clk);
            c_start = 1'b1;
            @(negedge clk);
            c_start = 1'b0;
            wait_valid(2, 1000, $sformatf("c_vec%0d", v));
            chk($sformatf("c_data[%0d]", v), c_data, c_vec[v].exp);
            chk($sformatf("c_sclk_falls[%0d]", v), c_nf, 16);
            chk($sformatf("c_sclk_span[%0d]", v), c_last_t - c_first_t, 300);
        end

        // START during SHIFT is dropped; START right after VALID is taken.
        n0 = a_ncnv;
        v0 = a_nvalid;
        a_go({14'h2ABC, 14'h0123});
        a_wait_cs_low();
        repeat (6) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_valid(0, 1000, "a_ign");
        chk("a_ign_data", a_data, 28'hAAF0123);
        tick();
        a_start = 1'b1;
        tick();
        chk("a_restart_cnvst_low", a_cnv, 0);
        a_start = 1'b0;
        wait_valid(0, 1000, "a_restart");
        repeat (30) tick();
        chk("a_ign_cnvst_pulses", a_ncnv - n0, 2);
        chk("a_ign_valid_pulses", a_nvalid - v0, 2);

        // One-cycle reset in the middle of SHIFT.
        v0 = a_nvalid;
        a_go({14'h1111, 14'h2222});
        a_wait_cs_low();
        repeat (10) tick();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_cs", a_cs, 1);
        chk("mid_rst_sclk", a_sclk, 1);
        chk("mid_rst_cnvst", a_cnv, 1);
        chk("mid_rst_data", a_data, 0);
        chk("mid_rst_ready", a_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) tick();
        chk("mid_rst_no_valid", a_nvalid - v0, 0);
        chk("mid_rst_idle", a_ready, 1);

        // BUSY watchdog on D.
        @(negedge clk);
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = !d_cnv;
        end
        chk("d_cnvst_low_seen", 64'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = d_cnv;
        end
        chk("d_wait_hi_entry", 64'(seen), 1);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            n++;
            seen = d_err;
        end
`ifdef ADC_BUSY_TIMEOUT_EN
        chk("d_err_seen", 64'(seen), 1);
        chk("d_timeout_cycles", n, 64);
        chk("d_timeout_ready", d_ready, 1);
        chk("d_timeout_data", d_data, 0);
        chk("d_timeout_valid", d_valid, 0);
        tick();
        chk("d_err_one_cycle", d_err, 0);
        chk("d_timeout_pins", {d_cnv, d_cs, d_sclk}, 3'b111);
`else
        chk("d_err_absent", 64'(seen), 0);
        chk("d_stuck_wait_hi", d_ready, 0);
        chk("d_stuck_pins", {d_cnv, d_cs, d_sclk, d_valid}, 4'b1110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
